bgm_sequencer: RTL and testbench

BGM_SEQUENCER -- requirements
Module: bgm_sequencer

---
 rtl/bgm_pkg.sv | 30 +++
 rtl/bgm_sequencer_if.sv | 28 ++
 rtl/bgm_note_lut.sv | 11 +
 rtl/bgm_sequencer.sv | 122 ++++++++++++
 tb/tb_bgm_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bgm_pkg.sv
// Shared widths, types and the note-code to tone-divider table for the BGM sequencer.
package bgm_pkg;

   localparam int NOTE_W  = 5;
   localparam int DUR_W   = 4;
   localparam int SCALE_W = 7;
   localparam int ROM_W   = NOTE_W + DUR_W;

   typedef logic [NOTE_W-1:0]  note_t;
   typedef logic [DUR_W-1:0]   dur_t;
   typedef logic [SCALE_W-1:0] scale_t;

   // Song ROM word layout: note code in the upper bits, duration below.
   typedef struct packed {
      note_t note;
      dur_t  dur;
   } rom_word_t;

   // Tone divider code per note code; 0 means silence.
   localparam scale_t SCALE_TABLE [2**NOTE_W] = '{
      7'd0,
      7'd92, 7'd87, 7'd82, 7'd77, 7'd73, 7'd69, 7'd65, 7'd61, 7'd58, 7'd55,
      7'd51, 7'd49, 7'd46, 7'd43, 7'd41, 7'd39, 7'd36, 7'd34, 7'd32, 7'd31,
      7'd29,
      7'd28,
      7'd27, 7'd26, 7'd24, 7'd23,
      7'd0,  7'd0,  7'd0,  7'd0,  7'd0
   };

endpackage

// File: rtl/bgm_sequencer_if.sv
// Control, song-ROM and tone-generator signals of the BGM sequencer.
// master = system/ROM side, slave = the sequencer itself.
interface bgm_sequencer_if #(
   parameter int ADDR_W = 9
);
   import bgm_pkg::*;

   logic [1:0]        scrnum;
   logic              pause;
   logic              loop_en;
   logic [1:0]        tempo_sel;
   logic [ADDR_W-1:0] rom_addr;
   logic [ROM_W-1:0]  rom_data;
   scale_t            scale;
   logic              note_start;
   logic              done;

   modport master (
      output scrnum, pause, loop_en, tempo_sel, rom_data,
      input  rom_addr, scale, note_start, done
   );

   modport slave (
      input  scrnum, pause, loop_en, tempo_sel, rom_data,
      output rom_addr, scale, note_start, done
   );

endinterface

// File: rtl/bgm_note_lut.sv
// Combinational note code to tone divider lookup.
module bgm_note_lut
   import bgm_pkg::*;
(
   input  note_t  note_i,
   output scale_t scale_o
);

   assign scale_o = SCALE_TABLE[note_i];

endmodule

// File: rtl/bgm_sequencer.sv
// Background-music sequencer: steps through an external song ROM at a
// selectable tempo and drives a tone divider code to the tone generator.
module bgm_sequencer
   import bgm_pkg::*;
#(
   parameter int         ADDR_W    = 9,
   parameter int         SONG_LEN  = 460,
   parameter int         TICK_DIV  = 10_000_000,
   parameter logic [3:0] PLAY_MASK = 4'b1010
) (
   input logic            clk,
   input logic            rst,
   bgm_sequencer_if.slave bus
);

   // Largest reload value is TICK_DIV-1.
   localparam int                CNT_W   = $clog2(TICK_DIV);
   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(SONG_LEN - 1);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   dur_t              dur_q, dur_d;
   logic              last_q, last_d;
   logic              done_q, done_d;
   scale_t            scale_q, scale_d;
   logic              note_start_q, note_start_d;

   logic              active;
   logic              tick;
   rom_word_t         rom_word;
   scale_t            lut_scale;
   logic [31:0]       period;
   logic [CNT_W-1:0]  reload;

   assign rom_word = rom_word_t'(bus.rom_data);
   assign active   = PLAY_MASK[bus.scrnum];
   assign tick     = active && !bus.pause && !done_q && (cnt_q == '0);

   bgm_note_lut u_note_lut (
      .note_i  (rom_word.note),
      .scale_o (lut_scale)
   );

   // Counter reload value at the tempo selected right now; guards tempos
   // whose period shrinks to a single cycle.
   always_comb begin
      period = 32'(TICK_DIV) >> bus.tempo_sel;
      reload = (period > 32'd1) ? CNT_W'(period - 32'd1) : '0;
   end

   // Next-state logic: inactivity clears everything, a tick advances the song,
   // otherwise the counter runs down unless paused.
   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
      pc_d         = pc_q;
      cnt_d        = cnt_q;
      dur_d        = dur_q;
      last_d       = last_q;
      done_d       = done_q;
      scale_d      = scale_q;
      note_start_d = 1'b0;

      if (!active) begin
         pc_d    = '0;
         cnt_d   = '0;
         dur_d   = '0;
         last_d  = 1'b0;
         done_d  = 1'b0;
         scale_d = '0;
      end else if (tick) begin
         cnt_d = reload;
         if (dur_q != '0) begin
            dur_d = dur_q - 1'b1;
         end else if (!last_q) begin
            scale_d      = lut_scale;
            dur_d        = rom_word.dur;
            note_start_d = 1'b1;
            // loop_en only matters here, at the load of the final entry.
            if (pc_q < LAST_PC) begin
               pc_d = pc_q + 1'b1;
            end else if (bus.loop_en) begin
               pc_d = '0;
            end else begin
               last_d = 1'b1;
            end
         end else begin
            scale_d = '0;
            done_d  = 1'b1;
         end
      end else if (!bus.pause && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         pc_q         <= '0;
         cnt_q        <= '0;
         dur_q        <= '0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         scale_q      <= '0;
         note_start_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         cnt_q        <= cnt_d;
         dur_q        <= dur_d;
         last_q       <= last_d;
         done_q       <= done_d;
         scale_q      <= scale_d;
         note_start_q <= note_start_d;
      end
   end

   assign bus.rom_addr   = pc_q;
   assign bus.scale      = bus.pause ? '0 : scale_q;
   assign bus.note_start = note_start_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_bgm_sequencer.sv
// Scoreboarded bench for bgm_sequencer with TICK_DIV=4, SONG_LEN=3.
module tb_bgm_sequencer;
   import bgm_pkg::*;

   typedef struct {
      logic [6:0] scale;
      int         cyc;
   } exp_t;

   localparam logic [6:0] REF_SCALE [32] = '{
      7'd0,  7'd92, 7'd87, 7'd82, 7'd77, 7'd73, 7'd69, 7'd65,
      7'd61, 7'd58, 7'd55, 7'd51, 7'd49, 7'd46, 7'd43, 7'd41,
      7'd39, 7'd36, 7'd34, 7'd32, 7'd31, 7'd29, 7'd28, 7'd27,
      7'd26, 7'd24, 7'd23, 7'd0,  7'd0,  7'd0,  7'd0,  7'd0
   };

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [8:0] rom [3];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       exp_q [$];

   bgm_sequencer_if #(.ADDR_W(9)) bus ();

   bgm_sequencer #(
      .ADDR_W    (9),
      .SONG_LEN  (3),
      .TICK_DIV  (4),
      .PLAY_MASK (4'b1010)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always_comb bus.rom_data = (bus.rom_addr < 9'd3) ? rom[bus.rom_addr[1:0]] : 9'h000;

   // Cycles since reset release: the first released edge is cycle 1.
   always @(posedge clk) begin
      if (!rst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // Scoreboard: every note_start must match the oldest expected load.
   always @(negedge clk) begin
      exp_t e;
      if (rst && bus.note_start) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL note_event: unexpected note_start at cycle %0d scale=%0d, none required", cyc, bus.scale);
         end else begin
            e = exp_q.pop_front();
            if (bus.scale !== e.scale || cyc != e.cyc) begin
               n_err++;
               $display("FAIL note_event: got scale=%0d at cycle %0d, required scale=%0d at cycle %0d",
                        bus.scale, cyc, e.scale, e.cyc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input logic [6:0] scale, input int c);
      exp_t e;
      e.scale = scale;
      e.cyc   = c;
      exp_q.push_back(e);
   endfunction

   task automatic set_rom_default();
      rom[0] = 9'h051;
      rom[1] = 9'h080;
      rom[2] = 9'h0A2;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      exp_q.delete();
      next_cycle();
      next_cycle();
   endtask

   task automatic check_drained(input string name);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: %0d expected note loads never seen, required 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      bus.scrnum = 2'd1; bus.pause = 1'b0; bus.loop_en = 1'b0; bus.tempo_sel = 2'd0;
      set_rom_default();
      rst = 1'b0;
      repeat (3) next_cycle();
      n_cmp++;
      if (bus.scale !== 7'd0 || bus.note_start !== 1'b0 || bus.done !== 1'b0 || bus.rom_addr !== 9'd0) begin
         n_err++;
         $display("FAIL reset_state: scale=%0d note_start=%b done=%b rom_addr=%0d, required all 0",
                  bus.scale, bus.note_start, bus.done, bus.rom_addr);
      end
   endtask

   task automatic test_song_end();
      int hold55 = 0;
      bus.scrnum = 2'd1; bus.loop_en = 1'b0;
      do_reset();
      rst = 1'b1;
      push(7'd73, 1); push(7'd61, 9); push(7'd55, 13);
      for (int c = 1; c <= 30; c++) begin
         next_cycle();
         if (bus.scale == 7'd55) hold55++;
         if (c == 14) bus.loop_en = 1'b1;
         if (c == 24) begin
            n_cmp++;
            if (bus.done !== 1'b0 || bus.scale !== 7'd55) begin
               n_err++;
               $display("FAIL end_before: done=%b scale=%0d, required done=0 scale=55", bus.done, bus.scale);
            end
         end
         if (c == 25) begin
            n_cmp++;
            if (bus.done !== 1'b1 || bus.scale !== 7'd0 || bus.rom_addr !== 9'd2) begin
               n_err++;
               $display("FAIL end_done: done=%b scale=%0d rom_addr=%0d, required 1/0/2",
                        bus.done, bus.scale, bus.rom_addr);
            end
         end
      end
      n_cmp++;
      if (hold55 != 12) begin
         n_err++;
         $display("FAIL last_entry_len: scale=55 for %0d cycles, required 12", hold55);
      end
      n_cmp++;
      if (bus.done !== 1'b1 || bus.rom_addr !== 9'd2) begin
         n_err++;
         $display("FAIL done_hold: done=%b rom_addr=%0d, required 1/2", bus.done, bus.rom_addr);
      end
      check_drained("song_end");
   endtask

   task automatic test_loop();
      int early = 0;
      bus.scrnum = 2'd1; bus.loop_en = 1'b1;
      do_reset();
      rst = 1'b1;
      push(7'd73, 1);  push(7'd61, 9);  push(7'd55, 13);
      push(7'd73, 25); push(7'd61, 33); push(7'd55, 37);
      for (int c = 1; c <= 52; c++) begin
         next_cycle();
         if (c == 14) bus.loop_en = 1'b0;
         if (c < 49 && bus.done !== 1'b0) early++;
         if (c == 49) begin
            n_cmp++;
            if (bus.done !== 1'b1 || bus.scale !== 7'd0) begin
               n_err++;
               $display("FAIL loop_second_end: done=%b scale=%0d, required 1/0", bus.done, bus.scale);
            end
         end
      end
      n_cmp++;
      if (early != 0) begin
         n_err++;
         $display("FAIL loop_no_done: done high on %0d cycles while looping, required 0", early);
      end
      check_drained("loop");
   endtask

   task automatic test_pause();
      int n73 = 0;
      int bad = 0;
      bus.scrnum = 2'd1; bus.loop_en = 1'b0;
      do_reset();
      rst = 1'b1;
      push(7'd73, 1); push(7'd61, 29); push(7'd55, 33);
      for (int c = 1; c <= 34; c++) begin
         next_cycle();
         if (bus.scale == 7'd73) n73++;
         if (c >= 4 && c <= 23 && (bus.scale !== 7'd0 || bus.rom_addr !== 9'd1)) bad++;
         if (c == 3)  bus.pause = 1'b1;
         if (c == 23) bus.pause = 1'b0;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL pause_mute: %0d paused cycles with scale!=0 or pc moved, required 0", bad);
      end
      n_cmp++;
      if (n73 != 8) begin
         n_err++;
         $display("FAIL pause_resume: scale=73 for %0d cycles, required 8", n73);
      end
      check_drained("pause");
   endtask

   task automatic test_tempo();
      int n73 = 0;
      bus.scrnum = 2'd1; bus.loop_en = 1'b0; bus.tempo_sel = 2'd1;
      do_reset();
      rst = 1'b1;
      push(7'd73, 1); push(7'd61, 5); push(7'd55, 7);
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         if (bus.scale == 7'd73) n73++;
      end
      n_cmp++;
      if (n73 != 4) begin
         n_err++;
         $display("FAIL tempo_len: entry 0 lasted %0d cycles, required 4", n73);
      end
      check_drained("tempo_fast");
      // Switching tempo mid-period must not cut the running period short.
      bus.tempo_sel = 2'd0;
      do_reset();
      rst = 1'b1;
      push(7'd73, 1); push(7'd61, 7); push(7'd55, 9);
      for (int c = 1; c <= 10; c++) begin
         next_cycle();
         if (c == 1) bus.tempo_sel = 2'd1;
      end
      check_drained("tempo_change");
      bus.tempo_sel = 2'd0;
   endtask

   task automatic test_screen();
      bus.scrnum = 2'd1; bus.loop_en = 1'b0;
      do_reset();
      rst = 1'b1;
      push(7'd73, 1); push(7'd61, 9); push(7'd55, 13);
      repeat (26) next_cycle();
      n_cmp++;
      if (bus.done !== 1'b1) begin
         n_err++;
         $display("FAIL screen_pre_done: done=%b, required 1", bus.done);
      end
      bus.scrnum = 2'd0;
      next_cycle();
      n_cmp++;
      if (bus.done !== 1'b0 || bus.scale !== 7'd0 || bus.rom_addr !== 9'd0 || bus.note_start !== 1'b0) begin
         n_err++;
         $display("FAIL screen_off: done=%b scale=%0d rom_addr=%0d note_start=%b, required all 0",
                  bus.done, bus.scale, bus.rom_addr, bus.note_start);
      end
      bus.scrnum = 2'd3;
      push(7'd73, 28);
      next_cycle();
      n_cmp++;
      if (bus.scale !== 7'd73 || bus.rom_addr !== 9'd1) begin
         n_err++;
         $display("FAIL screen_on3: scale=%0d rom_addr=%0d, required 73/1", bus.scale, bus.rom_addr);
      end
      repeat (2) next_cycle();
      bus.scrnum = 2'd2;
      next_cycle();
      n_cmp++;
      if (bus.scale !== 7'd0 || bus.rom_addr !== 9'd0) begin
         n_err++;
         $display("FAIL screen_off2: scale=%0d rom_addr=%0d, required 0/0", bus.scale, bus.rom_addr);
      end
      bus.scrnum = 2'd1;
      push(7'd73, 32);
      repeat (2) next_cycle();
      check_drained("screen");
   endtask

   task automatic test_reset_mid();
      bus.scrnum = 2'd1; bus.loop_en = 1'b0;
      do_reset();
      rst = 1'b1;
      push(7'd73, 1);
      repeat (3) next_cycle();
      rst = 1'b0;
      next_cycle();
      n_cmp++;
      if (bus.scale !== 7'd0 || bus.rom_addr !== 9'd0 || bus.note_start !== 1'b0 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_note: scale=%0d rom_addr=%0d note_start=%b done=%b, required all 0",
                  bus.scale, bus.rom_addr, bus.note_start, bus.done);
      end
      next_cycle();
      check_drained("reset_note");
      rst = 1'b1;
      push(7'd73, 1);
      repeat (3) next_cycle();
      bus.pause = 1'b1;
      repeat (2) next_cycle();
      rst = 1'b0;
      repeat (2) next_cycle();
      n_cmp++;
      if (bus.rom_addr !== 9'd0 || bus.note_start !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_pause: rom_addr=%0d note_start=%b, required 0/0", bus.rom_addr, bus.note_start);
      end
      check_drained("reset_pause");
      bus.pause = 1'b0;
      rst = 1'b1;
      push(7'd73, 1); push(7'd61, 9); push(7'd55, 13);
      repeat (26) next_cycle();
      n_cmp++;
      if (bus.done !== 1'b1) begin
         n_err++;
         $display("FAIL reset_pre_done: done=%b, required 1", bus.done);
      end
      rst = 1'b0;
      next_cycle();
      n_cmp++;
      if (bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done: done=%b, required 0", bus.done);
      end
      check_drained("reset_done");
   endtask

   task automatic test_lut();
      logic [4:0] code;
      bus.scrnum = 2'd1; bus.loop_en = 1'b0;
      for (int i = 0; i < 32; i++) begin
         code   = 5'(i);
         rom[0] = {code, 4'd0};
         do_reset();
         rst = 1'b1;
         push(REF_SCALE[i], 1);
         repeat (2) next_cycle();
         n_cmp++;
         if (bus.scale !== REF_SCALE[i]) begin
            n_err++;
            $display("FAIL lut_code%0d: scale=%0d, required %0d", i, bus.scale, REF_SCALE[i]);
         end
         check_drained("lut");
      end
      set_rom_default();
   endtask

   initial begin
      test_reset();
      test_song_end();
      test_loop();
      test_pause();
      test_tempo();
      test_screen();
      test_reset_mid();
      test_lut();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
